// File: rtl/envelope_generator.sv
// envelope_generator: per-voice ADSR amplitude stage scaling oscillator samples by a tick-driven envelope.
// Build with ENVELOPE_LEGATO_RETRIGGER_EN to retrigger from the current level instead of zero.
module envelope_generator #(
  parameter int AUDIO_BIT_WIDTH = 24,
  parameter int ENV_WIDTH = 16,
  parameter int TICK_DIV = 1042
) (
  input  logic                              clock_50_000_000,
  input  logic                              reset,
  input  logic                              gate,
  input  logic [ENV_WIDTH-1:0]              attack_step,
  input  logic [ENV_WIDTH-1:0]              decay_step,
  input  logic [ENV_WIDTH-1:0]              sustain_level,
  input  logic [ENV_WIDTH-1:0]              release_step,
  input  logic signed [AUDIO_BIT_WIDTH-1:0] sample_in,
  output logic signed [AUDIO_BIT_WIDTH-1:0] sample_out,
  output logic [ENV_WIDTH-1:0]              level,
  output logic                              active
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int PW = AUDIO_BIT_WIDTH + ENV_WIDTH + 1;
  localparam logic [ENV_WIDTH-1:0] MAX = '1;
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
  state_t state_q, state_d;
  logic [ENV_WIDTH-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic gate_q, tick, rise, fall;
  logic [ENV_WIDTH:0] sum;
  logic signed [ENV_WIDTH:0] dif;
  logic signed [PW-1:0] prod;
  logic signed [AUDIO_BIT_WIDTH-1:0] sample_q, sample_d;
  always_comb begin
    tick = cnt_q == CW'(TICK_DIV - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    rise = gate & ~gate_q;
    fall = ~gate & gate_q;
    sum = {1'b0, level_q} + {1'b0, attack_step};
    dif = $signed({1'b0, level_q}) - $signed({1'b0, decay_step});
    prod = sample_in * $signed({1'b0, level_q});
    sample_d = AUDIO_BIT_WIDTH'(prod >>> ENV_WIDTH);
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      IDLE: state_d = rise ? ATTACK : IDLE;
      ATTACK: if (tick) begin
        state_d = (attack_step == '0 || sum >= {1'b0, MAX}) ? DECAY : ATTACK;
        level_d = (attack_step == '0 || sum >= {1'b0, MAX}) ? MAX : sum[ENV_WIDTH-1:0];
      end
      DECAY: if (tick) begin
        state_d = (decay_step == '0 || dif <= $signed({1'b0, sustain_level})) ? SUSTAIN : DECAY;
        level_d = (decay_step == '0 || dif <= $signed({1'b0, sustain_level})) ? sustain_level : dif[ENV_WIDTH-1:0];
      end
      SUSTAIN: level_d = tick ? sustain_level : level_q;
      RELEASE: if (rise) begin
        state_d = ATTACK;
`ifdef ENVELOPE_LEGATO_RETRIGGER_EN
        level_d = level_q;
`else
        level_d = '0;
`endif
      end else if (tick) begin
        state_d = (release_step == '0 || level_q <= release_step) ? IDLE : RELEASE;
        level_d = (release_step == '0 || level_q <= release_step) ? '0 : level_q - release_step;
      end
      default: state_d = IDLE;
    endcase
    // a release request overrides the tick's state change but keeps its level result
    if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) state_d = RELEASE;
  end
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state_q <= IDLE;
      level_q <= '0;
      cnt_q <= '0;
      gate_q <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
      gate_q <= gate;
      sample_q <= sample_d;
    end
  end
  assign sample_out = sample_q;
  assign level = level_q;
  assign active = state_q != IDLE;
endmodule
